// File: rtl/bus_port_fifo_pkg.sv
// Shared definitions for the bus port: ID field geometry, default broadcast
// ID and the occupancy-counter width helper.
package bus_port_fifo_pkg;

  localparam int          ID_W         = 8;
  localparam logic [7:0]  BROADCAST_ID = 8'hFF;

  // A counter must reach depth itself, so it needs one bit beyond the address.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count; a read on the
// same edge as a write frees the slot, so a full queue can still accept.
module sync_fifo
  import bus_port_fifo_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [width-1:0]             wr_data,
  input  logic                         rd,
  output logic [width-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [cnt_width(depth)-1:0]  cnt
);

  localparam int aw = $clog2(depth);
  localparam int cw = cnt_width(depth);

  // Head must be visible combinationally, so storage is read asynchronously.
  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [cw-1:0]    cnt_reg, cnt_next;
  logic             wr_en, rd_en;

  assign empty = (cnt_reg == '0);
  assign full  = (cnt_reg == cw'(depth));
  assign rd_en = rd && !empty;
  assign wr_en = wr && (!full || rd_en);

  always_comb begin
    cnt_next = cnt_reg;
    if (wr_en && !rd_en) cnt_next = cnt_reg + 1'b1;
    else if (rd_en && !wr_en) cnt_next = cnt_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      cnt_reg <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
  assign cnt     = cnt_reg;

endmodule

// File: rtl/bus_port_fifo.sv
// Bus terminal: host TX queue toward the arbiter, ID-filtered RX queue from
// the bus, plus sticky overflow/drop flags.
module bus_port_fifo
  import bus_port_fifo_pkg::*;
#(
  parameter int         pckg_sz   = 16,
  parameter int         deep_fifo = 8,
  parameter logic [7:0] my_id     = 8'h00,
  parameter logic [7:0] broadcast = BROADCAST_ID
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tx_wr,
  input  logic [pckg_sz-1:0]               tx_data,
  output logic                             tx_full,
  output logic [cnt_width(deep_fifo)-1:0]  tx_cnt,
  output logic                             pndng,
  output logic [pckg_sz-1:0]               D_pop,
  input  logic                             pop,
  input  logic                             push,
  input  logic [pckg_sz-1:0]               D_push,
  input  logic                             rx_rd,
  output logic [pckg_sz-1:0]               rx_data,
  output logic                             rx_valid,
  output logic [cnt_width(deep_fifo)-1:0]  rx_cnt,
  output logic                             tx_ovf,
  output logic                             rx_drop,
  input  logic                             clr_flags
);

  logic            tx_empty, rx_empty, rx_full;
  logic            id_match, rx_wr;
  logic [ID_W-1:0] push_id;
  logic            tx_ovf_reg, tx_ovf_next, rx_drop_reg, rx_drop_next;

  assign push_id  = D_push[pckg_sz-1 -: ID_W];
  assign id_match = (push_id == my_id) || (push_id == broadcast);
  assign rx_wr    = push && id_match;

  sync_fifo #(.width(pckg_sz), .depth(deep_fifo)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .wr(tx_wr), .wr_data(tx_data),
    .rd(pop), .rd_data(D_pop),
    .full(tx_full), .empty(tx_empty), .cnt(tx_cnt)
  );

  sync_fifo #(.width(pckg_sz), .depth(deep_fifo)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .wr(rx_wr), .wr_data(D_push),
    .rd(rx_rd), .rd_data(rx_data),
    .full(rx_full), .empty(rx_empty), .cnt(rx_cnt)
  );

  assign pndng    = !tx_empty;
  assign rx_valid = !rx_empty;

  // A new loss event outranks a clear in the same cycle.
  always_comb begin
    tx_ovf_next  = tx_ovf_reg;
    rx_drop_next = rx_drop_reg;
    if (tx_wr && tx_full && !pop) tx_ovf_next = 1'b1;
    else if (clr_flags)           tx_ovf_next = 1'b0;
    if (rx_wr && rx_full && !rx_rd) rx_drop_next = 1'b1;
    else if (clr_flags)             rx_drop_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_ovf_reg  <= 1'b0;
      rx_drop_reg <= 1'b0;
    end else begin
      tx_ovf_reg  <= tx_ovf_next;
      rx_drop_reg <= rx_drop_next;
    end
  end

  assign tx_ovf  = tx_ovf_reg;
  assign rx_drop = rx_drop_reg;

endmodule
